// File: rtl/vliw_pkg.sv
// Shared types and widths for the VLIW writeback stage.
// Contents:
//   XLEN, REG_AW, STALL_CW  data width, register index width, stall counter width
//   slot_wb_t               one register-file write: destination, enable, data
//   wb_state_e              writeback FSM states
package vliw_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int STALL_CW = 16;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              we;
        logic [XLEN-1:0]   data;
    } slot_wb_t;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_slot_reg.sv
// One writeback slot register with x0 / invalid masking.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   kill         flush: drop the write and the destination, keep data
//   load         accept a new slot from EX
//   slot_in      EX slot; we already cleared by the caller if the slot lost arbitration
//   defer        hold the write back (load: rd is kept, we stays 0 until rsp)
//   hold         keep rd/data with we=0 while a deferred write is outstanding
//   rsp_valid    complete the deferred write with rsp_data
//   slot_out     registered RF write port
module wb_slot_reg
    import vliw_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            kill,
    input  logic            load,
    input  slot_wb_t        slot_in,
    input  logic            defer,
    input  logic            hold,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    output slot_wb_t        slot_out
);

    // A slot only writes (and is only visible to forwarding) if enabled and not x0.
    logic eff;
    assign eff = slot_in.we && (slot_in.rd != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_out <= '0;
        end else if (kill) begin
            slot_out.we <= 1'b0;
            slot_out.rd <= '0;
        end else if (load) begin
            slot_out.rd   <= eff ? slot_in.rd : '0;
            slot_out.we   <= eff & ~defer;
            slot_out.data <= slot_in.data;
        end else if (rsp_valid) begin
            slot_out.we   <= 1'b1;
            slot_out.data <= rsp_data;
        end else if (hold) begin
            slot_out.we <= 1'b0;
        end else begin
            slot_out.we <= 1'b0;
            slot_out.rd <= '0;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// EX->WB pipeline register for the three writing slots (ixu1, ixu2, lsu) of a VLIW bundle.
// Completes an outstanding load from the data-memory response and stalls EX meanwhile.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ex_valid / ex_ready            EX handshake (transfer = ex_valid & ex_ready)
//   flush                          kill held bundle and any pending load
//   ixu1_ex_*, ixu2_ex_*, lsu_ex_* slot inputs from EX
//   mem_rsp_valid, mem_rsp_data    load data return
//   ixu1_wb_*, ixu2_wb_*, lsu_wb_* RF write ports / forwarding sources
//   lsu_wb_is_load                 held lsu op is a load whose data is not yet available
//   conflict_err                   sticky: two slots of one bundle targeted the same rd
//   stall_cycles                   saturating count of cycles with ex_ready = 0
//
// state     | meaning
// IDLE      | no pending load, EX accepted every cycle
// WAIT_LOAD | held lsu load waiting for mem_rsp_valid, EX stalled
module wb_stage
    import vliw_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic                flush,
    input  logic [REG_AW-1:0]   ixu1_ex_rd,
    input  logic                ixu1_ex_we,
    input  logic [XLEN-1:0]     ixu1_ex_data,
    input  logic [REG_AW-1:0]   ixu2_ex_rd,
    input  logic                ixu2_ex_we,
    input  logic [XLEN-1:0]     ixu2_ex_data,
    input  logic [REG_AW-1:0]   lsu_ex_rd,
    input  logic                lsu_ex_we,
    input  logic                lsu_ex_is_load,
    input  logic [XLEN-1:0]     lsu_ex_data,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rsp_data,
    output logic [REG_AW-1:0]   ixu1_wb_rd,
    output logic                ixu1_wb_we,
    output logic [XLEN-1:0]     ixu1_wb_data,
    output logic [REG_AW-1:0]   ixu2_wb_rd,
    output logic                ixu2_wb_we,
    output logic [XLEN-1:0]     ixu2_wb_data,
    output logic [REG_AW-1:0]   lsu_wb_rd,
    output logic                lsu_wb_we,
    output logic [XLEN-1:0]     lsu_wb_data,
    output logic                lsu_wb_is_load,
    output logic                conflict_err,
    output logic [STALL_CW-1:0] stall_cycles
);

    wb_state_e state, state_nxt;
    logic      accept;
    logic      v1, v2, vl;
    logic      lose1, lose2;
    logic      waiting;
    slot_wb_t  ixu1_in, ixu2_in, lsu_in;
    slot_wb_t  ixu1_q, ixu2_q, lsu_q;

    assign waiting  = (state == WAIT_LOAD);
    assign ex_ready = (state == IDLE);
    // A bundle offered in a flush cycle is dropped even though ex_ready is high.
    assign accept   = ex_valid & ex_ready & ~flush;

    assign v1 = ixu1_ex_we && (ixu1_ex_rd != '0);
    assign v2 = ixu2_ex_we && (ixu2_ex_rd != '0);
    assign vl = lsu_ex_we  && (lsu_ex_rd  != '0);

    // WAW priority lsu > ixu2 > ixu1.
    assign lose2 = v2 && vl && (ixu2_ex_rd == lsu_ex_rd);
    assign lose1 = v1 && ((v2 && (ixu1_ex_rd == ixu2_ex_rd)) ||
                          (vl && (ixu1_ex_rd == lsu_ex_rd)));

    assign ixu1_in = '{rd: ixu1_ex_rd, we: ixu1_ex_we & ~lose1, data: ixu1_ex_data};
    assign ixu2_in = '{rd: ixu2_ex_rd, we: ixu2_ex_we & ~lose2, data: ixu2_ex_data};
    assign lsu_in  = '{rd: lsu_ex_rd,  we: lsu_ex_we,           data: lsu_ex_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept && vl && lsu_ex_is_load) state_nxt = WAIT_LOAD;
            WAIT_LOAD: if (mem_rsp_valid)                  state_nxt = IDLE;
            default:                                       state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_err <= 1'b0;
        end else if (accept && (lose1 || lose2)) begin
            conflict_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (!ex_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    wb_slot_reg u_ixu1 (
        .clk       (clk),
        .rst       (rst),
        .kill      (flush),
        .load      (accept),
        .slot_in   (ixu1_in),
        .defer     (1'b0),
        .hold      (1'b0),
        .rsp_valid (1'b0),
        .rsp_data  ('0),
        .slot_out  (ixu1_q)
    );

    wb_slot_reg u_ixu2 (
        .clk       (clk),
        .rst       (rst),
        .kill      (flush),
        .load      (accept),
        .slot_in   (ixu2_in),
        .defer     (1'b0),
        .hold      (1'b0),
        .rsp_valid (1'b0),
        .rsp_data  ('0),
        .slot_out  (ixu2_q)
    );

    wb_slot_reg u_lsu (
        .clk       (clk),
        .rst       (rst),
        .kill      (flush),
        .load      (accept),
        .slot_in   (lsu_in),
        .defer     (lsu_ex_is_load),
        .hold      (waiting),
        .rsp_valid (waiting & mem_rsp_valid),
        .rsp_data  (mem_rsp_data),
        .slot_out  (lsu_q)
    );

    assign ixu1_wb_rd     = ixu1_q.rd;
    assign ixu1_wb_we     = ixu1_q.we;
    assign ixu1_wb_data   = ixu1_q.data;
    assign ixu2_wb_rd     = ixu2_q.rd;
    assign ixu2_wb_we     = ixu2_q.we;
    assign ixu2_wb_data   = ixu2_q.data;
    assign lsu_wb_rd      = lsu_q.rd;
    assign lsu_wb_we      = lsu_q.we;
    assign lsu_wb_data    = lsu_q.data;
    assign lsu_wb_is_load = waiting;

endmodule
